brc_arbiter: RTL and testbench

BRC_ARBITER -- requirements
Module: brc_arbiter

---
 rtl/brc_pkg.sv | 25 ++
 rtl/brc_cmp_core.sv | 39 +++
 rtl/brc_arbiter.sv | 139 +++++++++++++
 tb/tb_brc_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/brc_pkg.sv
// Shared definitions for the branch-compare arbiter: compare op encoding
// (funct3), requester indices and the response FSM state type.
package brc_pkg;

  // Compare ops in funct3 encoding; 010 and 011 are reserved.
  typedef enum logic [2:0] {
    OP_EQ  = 3'b000,
    OP_NE  = 3'b001,
    OP_LT  = 3'b100,
    OP_GE  = 3'b101,
    OP_LTU = 3'b110,
    OP_GEU = 3'b111
  } brc_op_e;

  // Requester indices.
  localparam logic REQ_BRANCH = 1'b0;  // branch unit
  localparam logic REQ_SLT    = 1'b1;  // ALU set-less-than path

  // Response FSM: IDLE = nothing held, HOLD = registered response valid.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } brc_state_e;

endpackage

// File: rtl/brc_cmp_core.sv
// Shared combinational comparator: produces equal, less (signedness taken
// from the op) and the op's taken condition. Reserved ops give less=0 and
// taken=0 while still reporting equal.
module brc_cmp_core
  import brc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      op,
  output logic            less,
  output logic            equal,
  output logic            taken
);

  logic lt_signed;
  logic lt_unsigned;

  assign equal       = (rs1 == rs2);
  assign lt_signed   = ($signed(rs1) < $signed(rs2));
  assign lt_unsigned = (rs1 < rs2);

  // Select the less flag by op signedness and derive the taken condition.
  always_comb begin
    less  = 1'b0;
    taken = 1'b0;
    case (op)
      OP_EQ:  begin less = lt_signed;   taken = equal;        end
      OP_NE:  begin less = lt_signed;   taken = !equal;       end
      OP_LT:  begin less = lt_signed;   taken = lt_signed;    end
      OP_GE:  begin less = lt_signed;   taken = !lt_signed;   end
      OP_LTU: begin less = lt_unsigned; taken = lt_unsigned;  end
      OP_GEU: begin less = lt_unsigned; taken = !lt_unsigned; end
      default: begin less = 1'b0;       taken = 1'b0;         end
    endcase
  end

endmodule

// File: rtl/brc_arbiter.sv
// Two-requester arbiter in front of a single shared branch comparator.
// One request is granted per cycle; its compare result is registered and
// held until the consumer accepts it (1-cycle latency, full throughput).
// Config macro BRC_ARB_RR_EN: defined -> ties alternate round-robin;
// undefined -> ties always go to requester 0 and no pointer exists.
module brc_arbiter
  import brc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [1:0]      i_req_valid,
  output logic [1:0]      o_req_ready,
  input  logic [XLEN-1:0] i_req0_rs1,
  input  logic [XLEN-1:0] i_req0_rs2,
  input  logic [XLEN-1:0] i_req1_rs1,
  input  logic [XLEN-1:0] i_req1_rs2,
  input  logic [2:0]      i_req0_op,
  input  logic [2:0]      i_req1_op,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic            o_rsp_id,
  output logic            o_rsp_taken,
  output logic            o_rsp_less,
  output logic            o_rsp_equal
);

  brc_state_e state_reg;
  brc_state_e state_next;

  logic            grant;
  logic            accept_ok;
  logic            transfer;
  logic [XLEN-1:0] sel_rs1;
  logic [XLEN-1:0] sel_rs2;
  logic [2:0]      sel_op;
  logic            cmp_less;
  logic            cmp_equal;
  logic            cmp_taken;

`ifdef BRC_ARB_RR_EN
  // Index granted by the most recent transfer; reset to 1 so requester 0
  // wins the first tie.
  logic rr_ptr_reg;
`endif

  // Pick the requester: a lone request wins; a tie goes round-robin or to 0.
  always_comb begin
    grant = REQ_BRANCH;
    if (i_req_valid == 2'b10) begin
      grant = REQ_SLT;
    end else if (i_req_valid == 2'b11) begin
`ifdef BRC_ARB_RR_EN
      grant = (rr_ptr_reg == REQ_SLT) ? REQ_BRANCH : REQ_SLT;
`else
      grant = REQ_BRANCH;
`endif
    end
  end

  // A new request can land when nothing is held or the held one drains now.
  // Reset forces both ready bits low even though the state reads IDLE.
  assign accept_ok = i_rst_n && ((state_reg == ST_IDLE) || i_rsp_ready);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign o_req_ready[gi] = accept_ok && i_req_valid[gi] && (grant == 1'(gi));
    end
  endgenerate

  assign transfer = |o_req_ready;

  // Steer the granted requester's operands into the single comparator.
  assign sel_rs1 = (grant == REQ_SLT) ? i_req1_rs1 : i_req0_rs1;
  assign sel_rs2 = (grant == REQ_SLT) ? i_req1_rs2 : i_req0_rs2;
  assign sel_op  = (grant == REQ_SLT) ? i_req1_op  : i_req0_op;

  brc_cmp_core #(
    .XLEN(XLEN)
  ) u_cmp (
    .rs1   (sel_rs1),
    .rs2   (sel_rs2),
    .op    (sel_op),
    .less  (cmp_less),
    .equal (cmp_equal),
    .taken (cmp_taken)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: any transfer lands in HOLD; a drained HOLD with no new
  // transfer returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (transfer) state_next = ST_HOLD;
      ST_HOLD: if (i_rsp_ready && !transfer) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture the compare result and requester id on each transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_id    <= 1'b0;
      o_rsp_taken <= 1'b0;
      o_rsp_less  <= 1'b0;
      o_rsp_equal <= 1'b0;
    end else if (transfer) begin
      o_rsp_id    <= grant;
      o_rsp_taken <= cmp_taken;
      o_rsp_less  <= cmp_less;
      o_rsp_equal <= cmp_equal;
    end
  end

`ifdef BRC_ARB_RR_EN
  // Remember the last granted index; only a real transfer moves it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_reg <= REQ_SLT;
    end else if (transfer) begin
      rr_ptr_reg <= grant;
    end
  end
`endif

  assign o_rsp_valid = (state_reg == ST_HOLD);

endmodule

// File: tb/tb_brc_arbiter.sv
// Directed bench for brc_arbiter: reset values, signed/unsigned compares,
// arbitration ties (round-robin when BRC_ARB_RR_EN is defined, fixed
// priority otherwise), back-pressure, reserved ops and async reset.
module tb_brc_arbiter;

  logic        i_clk;
  logic        i_rst_n;
  logic [1:0]  i_req_valid;
  logic [1:0]  o_req_ready;
  logic [31:0] i_req0_rs1, i_req0_rs2, i_req1_rs1, i_req1_rs2;
  logic [2:0]  i_req0_op, i_req1_op;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic        o_rsp_id, o_rsp_taken, o_rsp_less, o_rsp_equal;

  int vectors;
  int miscompares;

  brc_arbiter #(.XLEN(32)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req0_rs1  (i_req0_rs1),
    .i_req0_rs2  (i_req0_rs2),
    .i_req1_rs1  (i_req1_rs1),
    .i_req1_rs2  (i_req1_rs2),
    .i_req0_op   (i_req0_op),
    .i_req1_op   (i_req1_op),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_taken (o_rsp_taken),
    .o_rsp_less  (o_rsp_less),
    .o_rsp_equal (o_rsp_equal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic exp_id;
    vectors     = 0;
    miscompares = 0;
    i_rst_n     = 1'b1;
    i_req_valid = 2'b11;
    i_rsp_ready = 1'b0;
    i_req0_rs1 = 32'h0; i_req0_rs2 = 32'h0; i_req0_op = 3'b000;
    i_req1_rs1 = 32'h0; i_req1_rs2 = 32'h0; i_req1_op = 3'b000;

    // Reset asserted with both requesters valid.
    #2 i_rst_n = 1'b0;
    repeat (2) tick();
    check("rst_valid", o_rsp_valid, 0);
    check("rst_id",    o_rsp_id,    0);
    check("rst_taken", o_rsp_taken, 0);
    check("rst_less",  o_rsp_less,  0);
    check("rst_equal", o_rsp_equal, 0);
    check("rst_ready", o_req_ready, 2'b00);

    // Release; req0 LT  -1 < 1 signed.
    i_rst_n     = 1'b1;
    i_req_valid = 2'b01;
    i_rsp_ready = 1'b1;
    i_req0_op = 3'b100; i_req0_rs1 = 32'hFFFF_FFFF; i_req0_rs2 = 32'h1;
    #1 check("lt_ready", o_req_ready, 2'b01);
    tick();
    check("lt_valid", o_rsp_valid, 1);
    check("lt_id",    o_rsp_id,    0);
    check("lt_less",  o_rsp_less,  1);
    check("lt_taken", o_rsp_taken, 1);

    // req1 LTU same operands: 0xFFFFFFFF is not below 1 unsigned.
    i_req_valid = 2'b10;
    i_req1_op = 3'b110; i_req1_rs1 = 32'hFFFF_FFFF; i_req1_rs2 = 32'h1;
    #1 check("ltu_ready", o_req_ready, 2'b10);
    tick();
    check("ltu_valid", o_rsp_valid, 1);
    check("ltu_id",    o_rsp_id,    1);
    check("ltu_less",  o_rsp_less,  0);
    check("ltu_taken", o_rsp_taken, 0);
    check("ltu_equal", o_rsp_equal, 0);

    // Tie for 4 cycles: req0 EQ (taken=1), req1 NE (taken=0), equal operands.
    // Last grant was requester 1, so round-robin starts at 0.
    i_req_valid = 2'b11;
    i_req0_op = 3'b000; i_req0_rs1 = 32'h5; i_req0_rs2 = 32'h5;
    i_req1_op = 3'b001; i_req1_rs1 = 32'h5; i_req1_rs2 = 32'h5;
    for (int i = 0; i < 4; i++) begin
`ifdef BRC_ARB_RR_EN
      exp_id = i[0];
`else
      exp_id = 1'b0;
`endif
      tick();
      check($sformatf("tie%0d_id", i), o_rsp_id, exp_id);
      check($sformatf("tie%0d_taken", i), o_rsp_taken, !exp_id);
    end

    // Load a known held response: req1 GE, -1 >= 1 signed is false.
    i_req_valid = 2'b10;
    i_req1_op = 3'b101; i_req1_rs1 = 32'hFFFF_FFFF; i_req1_rs2 = 32'h1;
    tick();
    check("ge_id",    o_rsp_id,    1);
    check("ge_less",  o_rsp_less,  1);
    check("ge_taken", o_rsp_taken, 0);

    // Back-pressure 3 cycles with req0 GEU 3,7 pending.
    i_rsp_ready = 1'b0;
    i_req_valid = 2'b01;
    i_req0_op = 3'b111; i_req0_rs1 = 32'h3; i_req0_rs2 = 32'h7;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("bp%0d_ready", i), o_req_ready, 2'b00);
      tick();
      check($sformatf("bp%0d_valid", i), o_rsp_valid, 1);
      check($sformatf("bp%0d_id", i),    o_rsp_id,    1);
      check($sformatf("bp%0d_less", i),  o_rsp_less,  1);
      check($sformatf("bp%0d_taken", i), o_rsp_taken, 0);
    end
    i_rsp_ready = 1'b1;
    #1 check("bp_rel_ready", o_req_ready, 2'b01);
    tick();
    check("geu_id",    o_rsp_id,    0);
    check("geu_less",  o_rsp_less,  1);
    check("geu_taken", o_rsp_taken, 0);

    // BEQ and BGE on 0x80000000 vs itself.
    i_req0_op = 3'b000; i_req0_rs1 = 32'h8000_0000; i_req0_rs2 = 32'h8000_0000;
    tick();
    check("beq_equal", o_rsp_equal, 1);
    check("beq_taken", o_rsp_taken, 1);
    i_req0_op = 3'b101;
    tick();
    check("bge_taken", o_rsp_taken, 1);
    check("bge_less",  o_rsp_less,  0);

    // Reserved ops: accepted, taken=0, less=0, equal still computed.
    i_req0_op = 3'b010; i_req0_rs1 = 32'h1; i_req0_rs2 = 32'h2;
    tick();
    check("rsv2_valid", o_rsp_valid, 1);
    check("rsv2_less",  o_rsp_less,  0);
    check("rsv2_taken", o_rsp_taken, 0);
    check("rsv2_equal", o_rsp_equal, 0);
    i_req0_op = 3'b011; i_req0_rs1 = 32'h9; i_req0_rs2 = 32'h9;
    tick();
    check("rsv3_equal", o_rsp_equal, 1);
    check("rsv3_taken", o_rsp_taken, 0);

    // Withdraw: response drains, back to IDLE.
    i_req_valid = 2'b00;
    tick();
    check("idle_valid", o_rsp_valid, 0);

    // Tie after last grant to requester 0.
    i_req_valid = 2'b11;
`ifdef BRC_ARB_RR_EN
    exp_id = 1'b1;
`else
    exp_id = 1'b0;
`endif
    tick();
    check("tie_idle_id", o_rsp_id, exp_id);

    // Async reset mid-HOLD, away from any clock edge.
    i_rsp_ready = 1'b0;
    i_req_valid = 2'b00;
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_valid", o_rsp_valid, 0);
    check("arst_ready", o_req_ready, 2'b00);
    check("arst_id",    o_rsp_id,    0);
    tick();
    i_rst_n = 1'b1;
    tick();
    check("post_arst_valid", o_rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
